mips_cpu_ifetch: RTL

Instruction-fetch initiator for the MIPS core; the requesting end of the instruction-memory read interface.
- Holds the fetch PC and issues one word read at a time, with a read/waitrequest handshake.
- Presents each fetched word to decode through a valid/ready handshake.
- Applies branch/jump redirects after the delay slot.
- Halts the core when control transfers to address 0.

---
 rtl/mips_cpu_pkg.sv | 27 ++
 rtl/mips_cpu_ifetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pkg
//  Description : Shared types and constants for the MIPS core front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  // Instruction-fetch controller states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
  localparam int          INSTR_WIDTH          = 32;

  // A fetch target must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_ifetch
//  Description : Instruction-fetch initiator. Issues one word read at a time
//                on the instruction-memory interface, hands each word to
//                decode over valid/ready, applies branch redirects after the
//                delay slot and halts when control reaches HALT_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // instruction-memory read interface
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  input  logic                   mem_waitrequest,
  input  logic [INSTR_WIDTH-1:0] mem_readdata,
  // redirect from decode
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  // instruction to decode
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [31:0]            instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  // status
  output logic                   active,
  output logic                   fetch_error
);

  ifetch_state_t r_state;
  logic [31:0]   r_fetch_pc;    // address of the fetch in flight / last fetched
  logic [31:0]   r_next_pc;     // PC chosen at completion, used when decode accepts
  logic          r_pending;     // a redirect is waiting for the next completion
  logic [31:0]   r_pend_tgt;

  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_fetch_next;
  logic [31:0]   w_hold_next;
  logic          w_complete;
  logic          w_accept;
  logic          w_latch_redirect;

  // Next-PC selection: a live redirect beats a pending one (latest wins),
  // and both beat sequential fetch. In HOLD a redirect replaces the PC that
  // the completion already chose, so the delay slot still goes out first.
  always_comb begin
    w_pc_plus4       = r_fetch_pc + 32'd4;
    w_fetch_next     = redirect_valid ? redirect_target
                     : (r_pending ? r_pend_tgt : w_pc_plus4);
    w_hold_next      = redirect_valid ? redirect_target : r_next_pc;
    w_complete       = (r_state == FETCH) && mem_read && !mem_waitrequest;
    w_accept         = instr_valid && instr_ready;
    w_latch_redirect = redirect_valid &&
                       ((r_state == IDLE) || ((r_state == FETCH) && !w_complete));
  end

  // Fetch state machine; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_VECTOR;
      r_next_pc   <= RESET_VECTOR;
      r_pending   <= 1'b0;
      r_pend_tgt  <= '0;
      mem_address <= RESET_VECTOR;
      mem_read    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      active      <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      // Redirects seen before the delay-slot fetch completes wait here
      if (w_latch_redirect) begin
        r_pending  <= 1'b1;
        r_pend_tgt <= redirect_target;
      end

      case (r_state)
        IDLE: begin
          r_state     <= FETCH;
          active      <= 1'b1;
          mem_read    <= 1'b1;
          mem_address <= r_fetch_pc;
        end

        FETCH: begin
          if (!mem_read) begin
            // issue cycle after an acceptance; address is already set up
            mem_read <= 1'b1;
          end else if (!mem_waitrequest) begin
            instr       <= mem_readdata;
            instr_pc    <= r_fetch_pc;
            instr_valid <= 1'b1;
            mem_read    <= 1'b0;
            r_next_pc   <= w_fetch_next;
            r_pending   <= 1'b0;
            r_state     <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            r_next_pc <= redirect_target;
          end
          if (w_accept) begin
            instr_valid <= 1'b0;
            if (w_hold_next == HALT_ADDR) begin
              r_state <= HALTED;
              active  <= 1'b0;
            end else if (is_misaligned(w_hold_next)) begin
              fetch_error <= 1'b1;
              r_state     <= HALTED;
              active      <= 1'b0;
            end else begin
              r_fetch_pc  <= w_hold_next;
              mem_address <= w_hold_next;
              r_state     <= FETCH;
            end
          end
        end

        HALTED: begin
          active      <= 1'b0;
          mem_read    <= 1'b0;
          instr_valid <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mips_cpu_ifetch
`default_nettype wire
